// File: rtl/muladd_pkg.sv
// Shared definitions for the multi-cycle arithmetic units (multiply-add, modulus).
// State encodings and the default operand width.
package muladd_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muladd_dp.sv
// Shift-and-add datapath: acc += mcand when mplier[0], then mcand <<= 1, mplier >>= 1.
// Single-cycle per step; load and step enables come from the control FSM.
module muladd_dp
    import muladd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   q_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [WIDTH-1:0]   r_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = {{WIDTH{1'b0}}, r_i};
            mcand_d  = {{WIDTH{1'b0}}, b_i};
            mplier_d = q_i;
        end else if (step_i) begin
            // Accumulator is 2*WIDTH wide, so q*b + r can never wrap here.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muladd_cu.sv
// Multi-cycle multiply-add (result = q*b + r) with start/done level handshake.
// done rises WIDTH+1 edges after start is accepted and holds until start drops.
module muladd_cu
    import muladd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] r_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o,
    output logic             done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;
    logic               done_q;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] acc;

    assign load = (state_q == ST_IDLE) && start_i;
    assign step = (state_q == ST_CALC);

    muladd_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .step_i (step),
        .q_i    (q_i),
        .b_i    (b_i),
        .r_i    (r_i),
        .acc_o  (acc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_CALC;
                        cnt_q   <= '0;
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle captures the settled accumulator; later ones wait for start to fall.
                    if (!done_q) begin
                        done_q   <= 1'b1;
                        result_q <= acc[WIDTH-1:0];
                        ovf_q    <= |acc[2*WIDTH-1:WIDTH];
                    end else if (!start_i) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ovf_o    = ovf_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_muladd_cu.sv
// Randomized bench for muladd_cu against a plain-arithmetic q*b + r reference.
module tb_muladd_cu;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] q_i, b_i, r_i;
    logic [31:0] result_o;
    logic        ovf_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit          busy       = 1'b0;
    bit          zero_phase = 1'b0;
    logic [31:0] m_res;
    logic        m_ovf;
    int          m_done_at;

    muladd_cu #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .q_i      (q_i),
        .b_i      (b_i),
        .r_i      (r_i),
        .result_o (result_o),
        .ovf_o    (ovf_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-precision product plus addend, split into low word and overflow flag.
    task automatic model(input logic [31:0] q, input logic [31:0] b, input logic [31:0] r);
        logic [63:0] full;
        full  = 64'(q) * 64'(b) + 64'(r);
        m_res = full[31:0];
        m_ovf = (full[63:32] != 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_ni || zero_phase) begin
            chk("reset_done", 64'(done_o), 64'd0);
            chk("reset_result", 64'(result_o), 64'd0);
            chk("reset_ovf", 64'(ovf_o), 64'd0);
        end else if (busy) begin
            if (cyc < m_done_at) begin
                chk("early_done", 64'(done_o), 64'd0);
            end else begin
                chk("done_held", 64'(done_o), 64'd1);
                chk("result", 64'(result_o), 64'(m_res));
                chk("ovf", 64'(ovf_o), 64'(m_ovf));
            end
        end
    end

    // Runs one request; chg_at>0 changes q that many cycles after start is raised.
    task automatic do_op(input logic [31:0] q, input logic [31:0] b, input logic [31:0] r,
                         input int hold, input int chg_at, input logic [31:0] chg_q);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #2;
        q_i = q; b_i = b; r_i = r; start_i = 1'b1;
        model(q, b, r);
        m_done_at = cyc + 34;
        busy = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #2;
            if (k == chg_at) q_i = chg_q;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(cyc), 64'(m_done_at));
            chk("first_result", 64'(result_o), 64'(m_res));
            chk("first_ovf", 64'(ovf_o), 64'(m_ovf));
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #2;
            q_i = $urandom; b_i = $urandom; r_i = $urandom;
        end
        start_i = 1'b0;
        busy = 1'b0;
        @(posedge clk); #2;
        chk("done_falls", 64'(done_o), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] rq, rb, rr;
        rst_ni = 1'b0; start_i = 1'b0; q_i = '0; b_i = '0; r_i = '0;
        zero_phase = 1'b1;
        #10;
        rst_ni = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        zero_phase = 1'b0;

        do_op(32'd2, 32'd4, 32'd2, 3, 0, 32'd0);
        chk("lit_roundtrip", 64'(result_o), 64'd10);

        do_op(32'd0, 32'hDEADBEEF, 32'd7, 1, 0, 32'd0);
        chk("lit_zero_mult", 64'(result_o), 64'd7);
        chk("lit_zero_mult_ovf", 64'(ovf_o), 64'd0);

        do_op(32'hFFFFFFFF, 32'd2, 32'd1, 2, 0, 32'd0);
        chk("lit_ovf_result", 64'(result_o), 64'hFFFFFFFF);
        chk("lit_ovf_flag", 64'(ovf_o), 64'd1);

        do_op(32'd3, 32'd5, 32'd1, 0, 10, 32'd9);
        chk("lit_midchange", 64'(result_o), 64'd16);

        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'd0);
        chk("lit_max_result", 64'(result_o), 64'h00000000);
        chk("lit_max_ovf", 64'(ovf_o), 64'd1);

        // Abort in the middle of a computation.
        @(posedge clk); #2;
        q_i = 32'h1234; b_i = 32'h5678; r_i = 32'd9; start_i = 1'b1;
        repeat (15) begin
            @(posedge clk); #2;
        end
        rst_ni = 1'b0;
        start_i = 1'b0;
        #1;
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_result", 64'(result_o), 64'd0);
        chk("abort_ovf", 64'(ovf_o), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        do_op(32'd6, 32'd7, 32'd0, 1, 0, 32'd0);
        chk("lit_after_abort", 64'(result_o), 64'd42);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0: begin rq = $urandom; rb = $urandom; rr = $urandom; end
                1: begin rq = $urandom_range(0, 255); rb = $urandom_range(0, 255); rr = $urandom_range(0, 255); end
                2: begin rq = 32'hFFFFFFFF - $urandom_range(0, 3); rb = $urandom; rr = 32'hFFFFFFFF; end
                default: begin rq = $urandom & 32'h0000FFFF; rb = $urandom & 32'h0000FFFF; rr = $urandom; end
            endcase
            do_op(rq, rb, rr, $urandom_range(0, 3), $urandom_range(1, 30), $urandom);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
